// File: rtl/count_mon_pkg.sv
// Shared encodings for the count window monitor: window FSM states and
// step-class codes reported by the step classifier.
package count_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_INSIDE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CLS_HOLD = 2'd0,
      CLS_STEP = 2'd1,
      CLS_WRAP = 2'd2,
      CLS_JUMP = 2'd3
   } step_class_e;

endpackage

// File: rtl/count_step_classifier.sv
// Remembers the previous count sample and classifies the current transition.
// Jump decode is built only when COUNT_WINDOW_MONITOR_JUMP_DETECT_EN is defined.
module count_step_classifier
   import count_mon_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] count,
   output step_class_e      step_class
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] prev_r;
   logic             prev_valid_r;
   logic [WIDTH-1:0] prev_inc_s;
   step_class_e      step_class_s;

   // Previous-sample register; disabling the monitor forgets the history.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r       <= ALL_ZERO;
         prev_valid_r <= 1'b0;
      end else if (enable) begin
         prev_r       <= count;
         prev_valid_r <= 1'b1;
      end else begin
         prev_r       <= prev_r;
         prev_valid_r <= 1'b0;
      end
   end

   assign prev_inc_s = prev_r + ONE;

   // Transition decode; wrap is tested before step so all-ones to zero never reads as a step.
   always_comb begin
      step_class_s = CLS_HOLD;
      if (!enable || !prev_valid_r) begin
         step_class_s = CLS_HOLD;
      end else if (count == prev_r) begin
         step_class_s = CLS_HOLD;
      end else if ((prev_r == ALL_ONES) && (count == ALL_ZERO)) begin
         step_class_s = CLS_WRAP;
      end else if (count == prev_inc_s) begin
         step_class_s = CLS_STEP;
      end else begin
`ifdef COUNT_WINDOW_MONITOR_JUMP_DETECT_EN
         step_class_s = CLS_JUMP;
`else
         // Discontinuities are not distinguished in this build.
         step_class_s = CLS_HOLD;
`endif
      end
   end

   assign step_class = step_class_s;

endmodule

// File: rtl/count_window_monitor.sv
// Observes a counter bus: window FSM with entry/exit pulses, wrap detection,
// saturating entry counter and sticky irq. Optional jump detection: COUNT_WINDOW_MONITOR_JUMP_DETECT_EN.
module count_window_monitor
   import count_mon_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int HIT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] count,
   input  logic             enable,
   input  logic [WIDTH-1:0] lo_thr,
   input  logic [WIDTH-1:0] hi_thr,
   input  logic             clear,
   output logic             in_window,
   output logic             enter_pulse,
   output logic             exit_pulse,
   output logic             wrap_pulse,
   output logic             jump_pulse,
   output logic [HIT_W-1:0] window_hits,
   output logic             irq
);

   localparam logic [HIT_W-1:0] HIT_MAX  = {HIT_W{1'b1}};
   localparam logic [HIT_W-1:0] HIT_ZERO = {HIT_W{1'b0}};
   localparam logic [HIT_W-1:0] HIT_ONE  = {{(HIT_W-1){1'b0}}, 1'b1};

   // An inverted window (lo > hi) can never satisfy both bounds, so it is empty.
   function automatic logic in_range_f(input logic [WIDTH-1:0] v,
                                       input logic [WIDTH-1:0] lo,
                                       input logic [WIDTH-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   state_e           state_r;
   state_e           next_state_s;
   step_class_e      step_class_s;
   logic             inside_s;
   logic             enter_s;
   logic             exit_s;
   logic             wrap_s;
   logic             jump_s;

   logic             in_window_r;
   logic             enter_r;
   logic             exit_r;
   logic             wrap_r;
   logic             jump_r;
   logic [HIT_W-1:0] hits_r;
   logic             irq_r;

   count_step_classifier #(
      .WIDTH (WIDTH)
   ) u_classifier (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .count      (count),
      .step_class (step_class_s)
   );

   assign inside_s = in_range_f(count, lo_thr, hi_thr);

   // Window FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; dropping enable returns to IDLE from anywhere.
   always_comb begin
      next_state_s = state_r;
      if (!enable) begin
         next_state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE:   next_state_s = inside_s ? ST_INSIDE : ST_ARMED;
            ST_ARMED:  next_state_s = inside_s ? ST_INSIDE : ST_ARMED;
            ST_INSIDE: next_state_s = inside_s ? ST_INSIDE : ST_ARMED;
            default:   next_state_s = ST_IDLE;
         endcase
      end
   end

   // Event decode from the state transition and the step class.
   always_comb begin
      enter_s = 1'b0;
      exit_s  = 1'b0;
      wrap_s  = 1'b0;
      jump_s  = 1'b0;
      if (enable) begin
         enter_s = (next_state_s == ST_INSIDE) && (state_r != ST_INSIDE);
         exit_s  = (next_state_s == ST_ARMED)  && (state_r == ST_INSIDE);
         wrap_s  = (step_class_s == CLS_WRAP);
`ifdef COUNT_WINDOW_MONITOR_JUMP_DETECT_EN
         jump_s  = (step_class_s == CLS_JUMP);
`else
         jump_s  = 1'b0;
`endif
      end else begin
         enter_s = 1'b0;
         exit_s  = 1'b0;
         wrap_s  = 1'b0;
         jump_s  = 1'b0;
      end
   end

   // Registered pulses and window flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_window_r <= 1'b0;
         enter_r     <= 1'b0;
         exit_r      <= 1'b0;
         wrap_r      <= 1'b0;
         jump_r      <= 1'b0;
      end else begin
         in_window_r <= (next_state_s == ST_INSIDE);
         enter_r     <= enter_s;
         exit_r      <= exit_s;
         wrap_r      <= wrap_s;
         jump_r      <= jump_s;
      end
   end

   // Saturating entry counter; clear wins over a same-cycle entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         hits_r <= HIT_ZERO;
      end else if (clear) begin
         hits_r <= HIT_ZERO;
      end else if (enter_s && (hits_r != HIT_MAX)) begin
         hits_r <= hits_r + HIT_ONE;
      end else begin
         hits_r <= hits_r;
      end
   end

   // Sticky interrupt; clear wins over a same-cycle set.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_r <= 1'b0;
      end else if (clear) begin
         irq_r <= 1'b0;
      end else if (exit_s || wrap_s || jump_s) begin
         irq_r <= 1'b1;
      end else begin
         irq_r <= irq_r;
      end
   end

   assign in_window   = in_window_r;
   assign enter_pulse = enter_r;
   assign exit_pulse  = exit_r;
   assign wrap_pulse  = wrap_r;
   assign jump_pulse  = jump_r;
   assign window_hits = hits_r;
   assign irq         = irq_r;

endmodule

// File: tb/tb_count_window_monitor.sv
// Self-checking bench for count_window_monitor: directed scenarios plus random
// traffic, all checked against a sample-by-sample behavioural model.
module tb_count_window_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] count = 8'd0;
   logic       enable = 1'b0;
   logic [7:0] lo_thr = 8'd0;
   logic [7:0] hi_thr = 8'd0;
   logic       clear = 1'b0;
   logic       in_window;
   logic       enter_pulse;
   logic       exit_pulse;
   logic       wrap_pulse;
   logic       jump_pulse;
   logic [3:0] window_hits;
   logic       irq;

   int n_checks = 0;
   int n_fail   = 0;

   // model state: previous sample, whether it is valid, window membership
   int m_prev = 0;
   bit m_pv   = 1'b0;
   bit m_inw  = 1'b0;
   int m_hits = 0;
   bit m_irq  = 1'b0;

   // observed-event accumulators for scenario-level checks
   int s_enter, s_exit, s_wrap, s_jump, s_inw;

   count_window_monitor #(.WIDTH(8), .HIT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .count       (count),
      .enable      (enable),
      .lo_thr      (lo_thr),
      .hi_thr      (hi_thr),
      .clear       (clear),
      .in_window   (in_window),
      .enter_pulse (enter_pulse),
      .exit_pulse  (exit_pulse),
      .wrap_pulse  (wrap_pulse),
      .jump_pulse  (jump_pulse),
      .window_hits (window_hits),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_acc();
      s_enter = 0; s_exit = 0; s_wrap = 0; s_jump = 0; s_inw = 0;
   endtask

   // One sample: drive on the falling edge, let the rising edge sample, check #1 later.
   task automatic do_step(input int c, input bit en, input int l, input int h,
                          input bit clr, input bit r);
      bit ins, e_inw, e_enter, e_exit, e_wrap, e_jump;
      @(negedge clk);
      count = c[7:0]; enable = en; lo_thr = l[7:0]; hi_thr = h[7:0]; clear = clr; rst = r;
      @(posedge clk);
      #1;
      e_inw = 1'b0; e_enter = 1'b0; e_exit = 1'b0; e_wrap = 1'b0; e_jump = 1'b0;
      if (r) begin
         m_prev = 0; m_pv = 1'b0; m_inw = 1'b0; m_hits = 0; m_irq = 1'b0;
      end else begin
         ins = (c >= l) && (c <= h);
         if (en) begin
            e_inw   = ins;
            e_enter = ins && !m_inw;
            e_exit  = !ins && m_inw;
            e_wrap  = m_pv && (m_prev == 255) && (c == 0);
`ifdef COUNT_WINDOW_MONITOR_JUMP_DETECT_EN
            e_jump  = m_pv && (c != m_prev) && (c != m_prev + 1) && !e_wrap;
`endif
            m_prev = c; m_pv = 1'b1;
         end else begin
            m_pv = 1'b0;
         end
         m_inw = e_inw;
         if (clr) m_hits = 0;
         else if (e_enter && m_hits < 15) m_hits++;
         if (clr) m_irq = 1'b0;
         else if (e_exit || e_wrap || e_jump) m_irq = 1'b1;
      end
      check("in_window",   32'(in_window),   32'(e_inw));
      check("enter_pulse", 32'(enter_pulse), 32'(e_enter));
      check("exit_pulse",  32'(exit_pulse),  32'(e_exit));
      check("wrap_pulse",  32'(wrap_pulse),  32'(e_wrap));
      check("jump_pulse",  32'(jump_pulse),  32'(e_jump));
      check("window_hits", 32'(window_hits), 32'(m_hits));
      check("irq",         32'(irq),         32'(m_irq));
      s_enter += int'(enter_pulse); s_exit += int'(exit_pulse);
      s_wrap  += int'(wrap_pulse);  s_jump += int'(jump_pulse);
      s_inw   += int'(in_window);
   endtask

   initial begin
      int c, l, h, sel;
      bit en, clr, r;

      // 1: reset with count=37, then release with enable low
      do_step(37, 1'b0, 0, 0, 1'b0, 1'b1);
      do_step(37, 1'b0, 0, 0, 1'b0, 1'b1);
      clr_acc();
      for (int i = 0; i < 4; i++) do_step(int'($urandom_range(0, 255)), 1'b0, 0, 255, 1'b0, 1'b0);
      check("idle_no_pulses", 32'(s_enter + s_exit + s_wrap + s_jump + s_inw), 32'd0);

      // 2: ramp 0..30 through window [10,20]
      clr_acc();
      for (int i = 0; i <= 30; i++) do_step(i, 1'b1, 10, 20, 1'b0, 1'b0);
      check("ramp_inw_cycles", 32'(s_inw), 32'd11);
      check("ramp_enters", 32'(s_enter), 32'd1);
      check("ramp_exits", 32'(s_exit), 32'd1);
      check("ramp_hits", 32'(window_hits), 32'd1);

      // 3: wrap 254,255,0,1 (clear on the first sample)
      do_step(254, 1'b1, 10, 20, 1'b1, 1'b0);
      check("pre_wrap_irq", 32'(irq), 32'd0);
      clr_acc();
      do_step(255, 1'b1, 10, 20, 1'b0, 1'b0);
      do_step(0,   1'b1, 10, 20, 1'b0, 1'b0);
      check("wrap_seen", 32'(wrap_pulse), 32'd1);
      do_step(1,   1'b1, 10, 20, 1'b0, 1'b0);
      check("wrap_once", 32'(s_wrap), 32'd1);
      check("wrap_irq", 32'(irq), 32'd1);
      check("wrap_no_jump", 32'(s_jump), 32'd0);

      // 4: load discontinuity 12 -> 50 with no window activity
      do_step(12, 1'b1, 100, 120, 1'b1, 1'b0);
      do_step(50, 1'b1, 100, 120, 1'b0, 1'b0);
`ifdef COUNT_WINDOW_MONITOR_JUMP_DETECT_EN
      check("jump_pulse_12_50", 32'(jump_pulse), 32'd1);
      check("jump_irq", 32'(irq), 32'd1);
`else
      check("jump_pulse_12_50", 32'(jump_pulse), 32'd0);
      check("jump_irq", 32'(irq), 32'd0);
`endif

      // 5: 17 entries saturate the counter, then clear with an 18th entry
      do_step(5, 1'b1, 10, 20, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) begin
         do_step(15, 1'b1, 10, 20, 1'b0, 1'b0);
         do_step(5,  1'b1, 10, 20, 1'b0, 1'b0);
      end
      check("hits_saturated", 32'(window_hits), 32'd15);
      do_step(15, 1'b1, 10, 20, 1'b1, 1'b0);
      check("hits_after_clear", 32'(window_hits), 32'd0);
      check("irq_after_clear", 32'(irq), 32'd0);
      check("enter_with_clear", 32'(enter_pulse), 32'd1);

      // 6: empty window sweep, then enable toggling at a fixed count
      clr_acc();
      for (int i = 0; i <= 255; i++) do_step(i, 1'b1, 200, 100, 1'b0, 1'b0);
      check("empty_enters", 32'(s_enter), 32'd0);
      check("empty_inw", 32'(s_inw), 32'd0);
      do_step(150, 1'b0, 200, 100, 1'b0, 1'b0);
      clr_acc();
      do_step(150, 1'b1, 200, 100, 1'b0, 1'b0);
      do_step(150, 1'b0, 200, 100, 1'b0, 1'b0);
      do_step(150, 1'b1, 200, 100, 1'b0, 1'b0);
      do_step(150, 1'b1, 200, 100, 1'b0, 1'b0);
      check("toggle_no_pulses", 32'(s_enter + s_exit + s_wrap + s_jump + s_inw), 32'd0);

      // 7: random traffic against the model
      c = 150; l = 10; h = 60;
      for (int i = 0; i < 600; i++) begin
         if (i % 60 == 0) begin
            l = int'($urandom_range(0, 255));
            h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                            : ((l + int'($urandom_range(0, 80))) % 256);
         end
         sel = int'($urandom_range(0, 99));
         if (sel < 70)      c = (c + 1) % 256;
         else if (sel < 82) c = c;
         else               c = int'($urandom_range(0, 255));
         en  = ($urandom_range(0, 19) != 0);
         clr = ($urandom_range(0, 29) == 0);
         r   = ($urandom_range(0, 149) == 0);
         do_step(c, en, l, h, clr, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
